// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch queue feeding the dispatch unit.
//
// Fetches 128-bit, 4-instruction lines from the instruction cache into a
// circular buffer of DEPTH lines. It presents one instruction at a time, in
// program order, together with its PC+4. A redirect flushes everything that is
// queued or in flight and restarts fetching at the target.
//
// Ports
//   clock              rising-edge clock
//   reset              asynchronous, active-low reset
//   ifetch_intruction  instruction at the read position
//   ifetch_pc_4        PC of the presented instruction + 4
//   ifetch_empty       1 = no valid instruction presented
//   Dispatch_ren       retire the presented instruction (ignored while empty)
//   Dispatch_jmp       redirect / flush request (wins over retire and return)
//   Dispatch_jmp_addr  redirect target, bits [1:0] ignored
//   Icache_rd_en       one-cycle registered fetch request
//   Icache_addr        16-byte aligned line address of the request
//   Icache_data        returned line, word k in bits [32k+31:32k]
//   Icache_valid       Icache_data valid this cycle (latency >= 1)
module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clock,
  input  logic         reset,
  output logic [31:0]  ifetch_intruction,
  output logic [31:0]  ifetch_pc_4,
  output logic         ifetch_empty,
  input  logic         Dispatch_ren,
  input  logic         Dispatch_jmp,
  input  logic [31:0]  Dispatch_jmp_addr,
  output logic         Icache_rd_en,
  output logic [31:0]  Icache_addr,
  input  logic [127:0] Icache_data,
  input  logic         Icache_valid
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   DEPTH_V = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] count;
  logic [PTR_W:0]   reserved;
  logic [1:0]       offset;
  logic [31:0]      fetch_pc;
  logic [31:0]      read_pc;
  logic             pending;
  logic             discard;
  logic             issue;
  logic             retire;
  logic [127:0]     line_q [DEPTH];

  // Pointers carry a wrap bit, so the difference is the occupancy even when
  // the buffer is completely full.
  assign count        = wptr - rptr;
  assign ifetch_empty = (count == '0);

  // An outstanding request already owns a slot; this keeps the returning
  // line from ever landing on a line that is still being read.
  assign reserved = {1'b0, count} + {{PTR_W{1'b0}}, pending};
  assign issue    = !pending && !Dispatch_jmp && (reserved < DEPTH_V);
  assign retire   = Dispatch_ren && !ifetch_empty && !Dispatch_jmp;

  assign ifetch_intruction = line_q[rptr[IDX_W-1:0]][{offset, 5'b0} +: 32];
  assign ifetch_pc_4       = read_pc + 32'd4;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr         <= '0;
      rptr         <= '0;
      offset       <= 2'd0;
      fetch_pc     <= RESET_PC;
      read_pc      <= RESET_PC;
      pending      <= 1'b0;
      discard      <= 1'b0;
      Icache_rd_en <= 1'b0;
      Icache_addr  <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      Icache_rd_en <= issue;
      if (issue) begin
        Icache_addr <= fetch_pc;
        pending     <= 1'b1;
      end

      if (Dispatch_jmp) begin
        rptr     <= wptr;
        fetch_pc <= Dispatch_jmp_addr & 32'hFFFF_FFF0;
        read_pc  <= Dispatch_jmp_addr & 32'hFFFF_FFFC;
        offset   <= Dispatch_jmp_addr[3:2];
        // A return landing in the jump cycle closes the request outright;
        // otherwise the late return still has to be swallowed.
        if (pending && Icache_valid) begin
          pending <= 1'b0;
          discard <= 1'b0;
        end else if (pending) begin
          discard <= 1'b1;
        end
      end else begin
        if (Icache_valid && pending) begin
          pending <= 1'b0;
          discard <= 1'b0;
          if (!discard) begin
            line_q[wptr[IDX_W-1:0]] <= Icache_data;
            wptr                    <= wptr + PTR_ONE;
            fetch_pc                <= fetch_pc + 32'd16;
          end
        end
        if (retire) begin
          read_pc <= read_pc + 32'd4;
          offset  <= offset + 2'd1;
          if (offset == 2'd3) begin
            rptr <= rptr + PTR_ONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue. Expected fetch addresses and expected
// retired instructions are queued by the stimulus; a monitor pops and compares
// them whenever the DUT issues a request or retires an instruction. A small
// cache model answers requests with a programmable latency.
module tb_ifetch_queue;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc4;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  ifetch_intruction;
  logic [31:0]  ifetch_pc_4;
  logic         ifetch_empty;
  logic         Dispatch_ren = 1'b0;
  logic         Dispatch_jmp = 1'b0;
  logic [31:0]  Dispatch_jmp_addr = 32'h0;
  logic         Icache_rd_en;
  logic [31:0]  Icache_addr;
  logic [127:0] Icache_data;
  logic         Icache_valid;

  int          n_chk = 0;
  int          n_pass = 0;
  int          req_seen = 0;
  int          lat = 2;
  bit          mode_index = 1'b1;
  int          cnt = 0;
  logic [31:0] req_addr = 32'h0;
  int          stray_req = 0;
  int          stray_seen = 0;

  logic [31:0] exp_req[$];
  exp_t        exp_ins[$];
  exp_t        mon_e;

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clock             (clock),
    .reset             (reset),
    .ifetch_intruction (ifetch_intruction),
    .ifetch_pc_4       (ifetch_pc_4),
    .ifetch_empty      (ifetch_empty),
    .Dispatch_ren      (Dispatch_ren),
    .Dispatch_jmp      (Dispatch_jmp),
    .Dispatch_jmp_addr (Dispatch_jmp_addr),
    .Icache_rd_en      (Icache_rd_en),
    .Icache_addr       (Icache_addr),
    .Icache_data       (Icache_data),
    .Icache_valid      (Icache_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp_v);
  endtask

  function automatic logic [127:0] mk_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      l[32*k +: 32] = mode_index ? 32'(k) : a + 32'(4 * k);
    end
    return l;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_ins(input logic [31:0] ins, input logic [31:0] pc4);
    exp_t e;
    e.ins = ins;
    e.pc4 = pc4;
    exp_ins.push_back(e);
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step(1);
      if (Icache_rd_en && Icache_addr == a) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL wait_req: no request to %h seen, one required", a);
    end
  endtask

  task automatic wait_nonempty();
    bit got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step(1);
      if (!ifetch_empty) got = 1'b1;
    end
    if (!got) begin
      n_chk++;
      $display("FAIL wait_nonempty: queue stayed empty, data required");
    end
  endtask

  // Cache model: answers each request `lat` cycles later; can also inject a
  // stray valid pulse that no request asked for.
  initial begin
    Icache_valid = 1'b0;
    Icache_data  = '0;
    forever begin
      @(negedge clock);
      Icache_valid = 1'b0;
      if (!reset) begin
        cnt = 0;
      end else begin
        if (stray_req != stray_seen) begin
          stray_seen   = stray_req;
          Icache_valid = 1'b1;
          Icache_data  = {4{32'hDEAD_BEEF}};
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            Icache_valid = 1'b1;
            Icache_data  = mk_line(req_addr);
          end
        end
        if (Icache_rd_en) begin
          req_addr = Icache_addr;
          if (lat <= 1) begin
            Icache_valid = 1'b1;
            Icache_data  = mk_line(req_addr);
          end else begin
            cnt = lat - 1;
          end
        end
      end
    end
  end

  // Monitor: compares every request and every retired instruction.
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        if (Icache_rd_en) begin
          req_seen++;
          if (exp_req.size() == 0) begin
            n_chk++;
            $display("FAIL req_addr: unexpected request to %h, none required", Icache_addr);
          end else begin
            check("req_addr", Icache_addr, exp_req.pop_front());
          end
        end
        if (Dispatch_ren && !Dispatch_jmp && !ifetch_empty) begin
          if (exp_ins.size() == 0) begin
            n_chk++;
            $display("FAIL retire: unexpected retire of %h, none required", ifetch_intruction);
          end else begin
            mon_e = exp_ins.pop_front();
            check("instr", ifetch_intruction, mon_e.ins);
            check("pc_4", ifetch_pc_4, mon_e.pc4);
          end
        end
      end
    end
  end

  initial begin
    int base;
    int n;
    bit hit;

    // Power-on reset state
    step(3);
    check("rst_empty", 32'(ifetch_empty), 32'd1);
    check("rst_rd_en", 32'(Icache_rd_en), 32'd0);
    check("rst_addr", Icache_addr, 32'h0);
    check("rst_pc4", ifetch_pc_4, 32'h4);
    check("rst_instr", ifetch_intruction, 32'h0);

    // Fill to full with no retires: exactly four requests
    for (int k = 0; k < 4; k++) exp_req.push_back(32'(16 * k));
    base  = req_seen;
    reset = 1'b1;
    wait_nonempty();
    check("first_instr", ifetch_intruction, 32'h0);
    check("first_pc4", ifetch_pc_4, 32'h4);
    step(30);
    check("full_req_count", 32'(req_seen - base), 32'd4);
    check("full_not_empty", 32'(ifetch_empty), 32'd0);

    // Retiring one line frees a slot for 0x40
    for (int k = 0; k < 4; k++) push_ins(32'(k), 32'(4 * k + 4));
    exp_req.push_back(32'h40);
    Dispatch_ren = 1'b1;
    step(4);
    Dispatch_ren = 1'b0;
    wait_req(32'h40);

    // Reset in the middle of the 0x40 fetch
    @(negedge clock);
    #1;
    reset = 1'b0;
    step(2);
    check("midrst_empty", 32'(ifetch_empty), 32'd1);
    check("midrst_rd_en", 32'(Icache_rd_en), 32'd0);
    check("midrst_pc4", ifetch_pc_4, 32'h4);

    // Streaming across line and pointer wrap; a stray valid at release
    mode_index = 1'b0;
    for (int k = 0; k < 12; k++) exp_req.push_back(32'(16 * k));
    for (int i = 0; i < 32; i++) push_ins(32'(4 * i), 32'(4 * i + 4));
    stray_req++;
    reset        = 1'b1;
    Dispatch_ren = 1'b1;
    step(1);
    check("release_rd_en", 32'(Icache_rd_en), 32'd1);
    check("release_addr", Icache_addr, 32'h0);
    check("stray_ignored", 32'(ifetch_empty), 32'd1);
    n = 0;
    for (int c = 0; c < 300 && n < 32; c++) begin
      @(negedge clock);
      if (!ifetch_empty) n++;
      @(posedge clock);
      #1;
    end
    Dispatch_ren = 1'b0;
    check("stream_retired", 32'(n), 32'd32);
    step(40);
    check("stream_head_instr", ifetch_intruction, 32'h80);
    check("stream_head_pc4", ifetch_pc_4, 32'h84);

    // Jump while the 0x20 fetch is outstanding
    reset = 1'b0;
    step(2);
    lat = 4;
    foreach (exp_req[i]) exp_req.delete(i);
    exp_req.push_back(32'h0);
    exp_req.push_back(32'h10);
    exp_req.push_back(32'h20);
    for (int k = 0; k < 4; k++) exp_req.push_back(32'h100 + 32'(16 * k));
    reset = 1'b1;
    wait_req(32'h20);
    Dispatch_jmp      = 1'b1;
    Dispatch_jmp_addr = 32'h0000_010B;
    step(1);
    Dispatch_jmp = 1'b0;
    check("jmp_empty", 32'(ifetch_empty), 32'd1);
    check("jmp_pc4", ifetch_pc_4, 32'h10C);
    step(50);
    check("jmp_first_instr", ifetch_intruction, 32'h108);
    push_ins(32'h108, 32'h10C);
    push_ins(32'h10C, 32'h110);
    push_ins(32'h110, 32'h114);
    exp_req.push_back(32'h140);
    Dispatch_ren = 1'b1;
    step(3);
    Dispatch_ren = 1'b0;

    // Jump, retire and return all in one cycle
    push_ins(32'h114, 32'h118);
    push_ins(32'h118, 32'h11C);
    push_ins(32'h11C, 32'h120);
    exp_req.push_back(32'h150);
    Dispatch_ren = 1'b1;
    step(3);
    Dispatch_ren = 1'b0;
    wait_req(32'h150);
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1);
      if (cnt == 1) hit = 1'b1;
    end
    if (!hit) begin
      n_chk++;
      $display("FAIL collide_setup: 0x150 return never scheduled, required");
    end
    for (int k = 0; k < 4; k++) exp_req.push_back(32'h40 + 32'(16 * k));
    Dispatch_jmp      = 1'b1;
    Dispatch_jmp_addr = 32'h44;
    Dispatch_ren      = 1'b1;
    step(1);
    Dispatch_jmp = 1'b0;
    check("collide_empty", 32'(ifetch_empty), 32'd1);
    check("collide_pc4", ifetch_pc_4, 32'h48);
    // Retire held high while empty must not move the read position
    step(1);
    check("ren_empty_empty", 32'(ifetch_empty), 32'd1);
    check("ren_empty_pc4", ifetch_pc_4, 32'h48);
    Dispatch_ren = 1'b0;
    step(40);
    check("collide_head_instr", ifetch_intruction, 32'h44);
    push_ins(32'h44, 32'h48);
    push_ins(32'h48, 32'h4C);
    Dispatch_ren = 1'b1;
    step(2);
    Dispatch_ren = 1'b0;
    step(10);

    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("ins_queue_drained", 32'(exp_ins.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue (IFQ) directly upstream of `dispatch_unit`. It fetches 128-bit (4-instruction) lines from the instruction cache into a circular line buffer and presents one instruction at a time, in program order, with its PC+4. It retires an instruction on `Dispatch_ren`. On `Dispatch_jmp` it flushes all queued and in-flight fetches and refetches from `Dispatch_jmp_addr`.

## Interface
- `DEPTH`, 4: number of 128-bit lines held. Power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset. 16-byte aligned.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ifetch_intruction`  out  32  instruction at the read position.
- `ifetch_pc_4`  out  32  PC of that instruction + 4.
- `ifetch_empty`  out  1  1 = no valid instruction presented.
- `Dispatch_ren`  in  1  retire the presented instruction. Ignored while empty.
- `Dispatch_jmp`  in  1  redirect/flush request.
- `Dispatch_jmp_addr`  in  32  redirect target. Bits [1:0] are ignored.
- `Icache_rd_en`  out  1  one-cycle fetch request pulse.
- `Icache_addr`  out  32  line address, bits [3:0] = 0.
- `Icache_data`  in  128  returned line. Word k is in bits [32k+31:32k].
- `Icache_valid`  in  1  `Icache_data` is valid this cycle. Any latency ≥1 cycle after the request.

## Operation
- **State:**
  - `wptr`, `rptr`: log2(DEPTH)+1 bits each, with a wrap bit.
  - `offset`: 2-bit word index within the head line.
  - `fetch_pc`: next line address.
  - `read_pc`: PC of the presented instruction.
  - `pending`: one request outstanding.
  - `discard`: the outstanding return must be dropped.
- **Reset:**
  - `wptr = rptr = 0`, `offset = 0`, `pending = discard = 0`.
  - `fetch_pc = read_pc = RESET_PC`.
  - Outputs: `ifetch_empty = 1`, `Icache_rd_en = 0`, `Icache_addr = RESET_PC`, `ifetch_pc_4 = RESET_PC + 4`, `ifetch_intruction = 0`.
- **Occupancy:** `count = wptr − rptr`.
  - Full when `count == DEPTH`.
  - Empty when `count == 0`.
  - `ifetch_empty = (count == 0)`.
- **Fetch:** issue a request when `!pending && !Dispatch_jmp && count < DEPTH`.
  - The request counts as a reserved slot: no request is issued if `count + pending ≥ DEPTH`.
  - On the request cycle: `Icache_rd_en = 1`, `Icache_addr = fetch_pc`, and `pending` is set.
- **Return:** on `Icache_valid && pending && !discard`:
  - `line[wptr] = Icache_data`, `wptr++`, `fetch_pc += 16`, `pending` clears.
  - If `discard` is set: the data is dropped, and `pending` and `discard` both clear.
  - `Icache_valid` while `!pending` is ignored.
- **Output (combinational from registers):**
  - `ifetch_intruction = line[rptr][32*offset +: 32]`.
  - `ifetch_pc_4 = read_pc + 4`.
- **Retire:** on `Dispatch_ren && !ifetch_empty && !Dispatch_jmp`:
  - `read_pc += 4`, `offset++`.
  - When `offset == 3`, `rptr` also increments and `offset` wraps to 0.
- **Jump:** `Dispatch_jmp` has priority over retire and over the write of a return in the same cycle.
  - `rptr = wptr`, so the queue is empty.
  - `fetch_pc = {addr[31:4], 4'b0}`, `read_pc = {addr[31:2], 2'b0}`, `offset = addr[3:2]`.
  - If `pending`, set `discard`; if `Icache_valid` arrives in the jump cycle, that return is dropped.
  - No request is issued in the jump cycle.
- **Pointer wrap:** pointers wrap modulo 2·DEPTH, and the line index wraps modulo DEPTH. `fetch_pc` and `read_pc` wrap at 2^32.

## Timing
- **Request:** registered, one cycle wide.
- **Next request:** the earliest next request is the cycle after the return.
- **Return to visible:** a line returned at edge T is visible at T, with `ifetch_empty` falling after that edge.
- **Jump to first instruction:** jump at edge N; request at cycle N+1; return after L cycles; first instruction visible the cycle after the return, i.e. N+1+L.
- **Retire throughput:** one instruction per cycle while non-empty.
- **Simultaneous return and retire of the last word of the head line:** `count` is unchanged.
- **Reset mid-fetch:** the pending request is abandoned. A later `Icache_valid` is ignored because `pending = 0`.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream, then release. Required response:
  - `ifetch_empty = 1`.
  - First edge after release: `Icache_rd_en = 1`, `Icache_addr = 0`.
  - Return line {0x3,0x2,0x1,0x0} (word 0 = 0x0): then `ifetch_intruction = 0x0`, `ifetch_pc_4 = 4`.
- **Streaming:** latency 2, `Dispatch_ren = 1` continuously, word value = PC.
  - Instructions 0x0, 0x4, … 0x3C come out in order with `ifetch_pc_4 = PC + 4`.
  - No duplicates or gaps across line and pointer wrap.
- **Full:** `Dispatch_ren = 0`, DEPTH = 4.
  - Exactly 4 requests (0x0, 0x10, 0x20, 0x30), then none.
  - Four retires free the line, and then a request to 0x40 is issued.
- **Jump with pending:** request to 0x20 outstanding, pulse `Dispatch_jmp` with addr 0x108.
  - The 0x20 return is dropped.
  - Next request is to 0x100.
  - First presented instruction is word 2 with `ifetch_pc_4 = 0x10C`.
- **Jump vs. retire/return collision:** `Dispatch_jmp`, `Dispatch_ren` and `Icache_valid` in the same cycle, jump to 0x44.
  - Queue becomes empty and the return is not written.
  - Next request is to 0x40; first instruction has `ifetch_pc_4 = 0x48`.
- **Retire while empty:** `Dispatch_ren = 1` with `ifetch_empty = 1`.
  - `read_pc`, `rptr` and `offset` are unchanged.
